// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a count/payload/checksum byte frame, writes
// little-endian words into instruction memory and holds the core in reset until verified.
module imem_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CntW     = ADDR_W + 1;
  localparam int unsigned MaxWords = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    StCntLo,
    StCntHi,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  state_e              state_q;
  logic [7:0]          cnt_lo_q;
  logic [CntW-1:0]     count_q;
  logic [1:0]          byte_idx_q;
  logic [23:0]         word_q;
  logic [7:0]          csum_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [CntW-1:0]     words_q;

  logic                accept;
  logic [15:0]         full_count;
  logic [CntW-1:0]     words_inc;

  assign in_ready   = (state_q == StCntLo) || (state_q == StCntHi) ||
                      (state_q == StData)  || (state_q == StCsum);
  assign accept     = in_valid && in_ready;
  assign full_count = {in_data, cnt_lo_q};
  assign words_inc  = words_q + CntW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StCntLo;
      cnt_lo_q   <= 8'h00;
      count_q    <= '0;
      byte_idx_q <= 2'd0;
      word_q     <= 24'h0;
      csum_q     <= 8'h00;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      words_q    <= '0;
    end else begin
      we_q <= 1'b0;
      if (accept) begin
        case (state_q)
          StCntLo: begin
            cnt_lo_q <= in_data;
            state_q  <= StCntHi;
          end
          StCntHi: begin
            count_q <= CntW'(full_count);
            if (32'(full_count) > MaxWords) begin
              state_q <= StErr;
            end else if (full_count == 16'h0) begin
              state_q <= StCsum;
            end else begin
              state_q <= StData;
            end
          end
          StData: begin
            csum_q     <= csum_q ^ in_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: word_q[7:0]   <= in_data;
              2'd1: word_q[15:8]  <= in_data;
              2'd2: word_q[23:16] <= in_data;
              default: begin
                // Fourth byte completes the word; write pulse and count share this edge.
                we_q    <= 1'b1;
                addr_q  <= words_q[ADDR_W-1:0];
                wdata_q <= {in_data, word_q};
                words_q <= words_inc;
                if (words_inc == count_q) begin
                  state_q <= StCsum;
                end
              end
            endcase
          end
          StCsum: begin
            state_q <= (in_data == csum_q) ? StDone : StErr;
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign words_loaded = words_q;
  assign core_reset   = (state_q != StDone);
  assign done         = (state_q == StDone);
  assign error        = (state_q == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven frames plus hand sequences, with a
// write scoreboard fed by a frame parser model as bytes are driven.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned MaxW   = 2 ** ADDR_W;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]       data;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       due;
  } exp_wr_t;

  typedef struct packed {
    logic [15:0][7:0] b;
    logic [4:0]       len;
    logic             idle;
    logic             exp_done;
    logic             exp_err;
    logic [10:0]      exp_words;
  } vec_t;

  exp_wr_t sb[$];
  int      tests;
  int      fails;
  int      cyc;

  // Frame parser model
  int          m_pos;
  int          m_n;
  logic [7:0]  m_lo;
  bit          m_term;
  logic [31:0] m_word;

  logic [7:0] t1 [11] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00,
                          8'h71};
  vec_t       v [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic exp_we;
    @(posedge clk);
    #1;
    cyc++;
    exp_we = (sb.size() > 0) && (sb[0].due == 32'(cyc));
    chk("imem_we", 32'(imem_we), 32'(exp_we));
    if (exp_we) begin
      chk("imem_addr", 32'(imem_addr), 32'(sb[0].addr));
      chk("imem_wdata", imem_wdata, sb[0].data);
      void'(sb.pop_front());
    end
  endtask

  task automatic model_accept(input logic [7:0] b);
    int idx;
    if (m_pos == 0) begin
      m_lo = b;
    end else if (m_pos == 1) begin
      m_n = int'({b, m_lo});
      if (m_n > int'(MaxW)) m_term = 1'b1;
    end else if (m_pos < 4 * m_n + 2) begin
      idx = (m_pos - 2) % 4;
      m_word[8*idx +: 8] = b;
      if (idx == 3) begin
        sb.push_back('{data: m_word, addr: ADDR_W'((m_pos - 2) / 4), due: 32'(cyc + 1)});
      end
    end else begin
      m_term = 1'b1;
    end
    m_pos++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    chk("in_ready", 32'(in_ready), 32'(!m_term));
    in_valid = 1'b1;
    in_data  = b;
    if (!m_term) model_accept(b);
    tick();
    in_valid = 1'b0;
    in_data  = 8'hFF;
  endtask

  task automatic idle_tick();
    in_valid = 1'b0;
    in_data  = 8'hFF;
    tick();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset    = 1'b0;
    sb.delete();
    tick();
    reset  = 1'b1;
    m_pos  = 0;
    m_n    = 0;
    m_lo   = 8'h00;
    m_term = 1'b0;
    m_word = 32'h0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " imem_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, " imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, " core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " error"}, 32'(error), 32'd0);
    chk({tag, " words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic check_final(input string tag, input bit exp_done, input bit exp_err,
                             input int exp_words);
    chk({tag, " done"}, 32'(done), 32'(exp_done));
    chk({tag, " error"}, 32'(error), 32'(exp_err));
    chk({tag, " core_reset"}, 32'(core_reset), 32'(!exp_done));
    chk({tag, " words_loaded"}, 32'(words_loaded), 32'(exp_words));
    chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, " pending writes"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  cs;
    tests    = 0;
    fails    = 0;
    cyc      = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    for (int i = 0; i < 6; i++) v[i] = '0;
    for (int j = 0; j < 11; j++) begin
      v[0].b[j] = t1[j];
      v[1].b[j] = t1[j];
      v[5].b[j] = t1[j];
    end
    v[0].len = 5'd11; v[0].exp_done = 1'b1; v[0].exp_words = 11'd2;
    v[1].b[10] = 8'h70;
    v[1].len = 5'd11; v[1].exp_err = 1'b1; v[1].exp_words = 11'd2;
    v[2].len = 5'd3;  v[2].exp_done = 1'b1;
    v[3].b[2] = 8'h5A;
    v[3].len = 5'd3;  v[3].exp_err = 1'b1;
    v[4].b[0] = 8'h01; v[4].b[1] = 8'h04; v[4].b[2] = 8'hAA; v[4].b[3] = 8'hBB;
    v[4].b[4] = 8'hCC;
    v[4].len = 5'd5;  v[4].exp_err = 1'b1;
    v[5].len = 5'd11; v[5].idle = 1'b1; v[5].exp_done = 1'b1; v[5].exp_words = 11'd2;

    do_reset();
    check_reset_vals("reset");

    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int j = 0; j < int'(v[i].len); j++) begin
        if (v[i].idle) begin
          repeat ($urandom_range(0, 3)) idle_tick();
        end
        send_byte(v[i].b[j]);
      end
      repeat (2) idle_tick();
      check_final($sformatf("vec%0d", i), v[i].exp_done, v[i].exp_err, int'(v[i].exp_words));
    end

    // Oversize count flags error immediately after the high count byte.
    do_reset();
    send_byte(8'h01);
    send_byte(8'h04);
    chk("oversize error now", 32'(error), 32'd1);
    chk("oversize in_ready now", 32'(in_ready), 32'd0);

    // Reset mid-load, then a clean replay.
    do_reset();
    for (int j = 0; j < 7; j++) send_byte(t1[j]);
    do_reset();
    chk("midreset imem_we", 32'(imem_we), 32'd0);
    check_reset_vals("midreset");
    for (int j = 0; j < 11; j++) send_byte(t1[j]);
    check_final("replay", 1'b1, 1'b0, 2);

    // Full-size image: last write at address MaxW-1, words_loaded reaches MaxW.
    do_reset();
    cs = 8'h00;
    send_byte(8'h00);
    send_byte(8'h04);
    for (int k = 0; k < int'(MaxW); k++) begin
      w = (32'(k) * 32'h0100_0193) ^ 32'hA5A5_5A5A;
      for (int q = 0; q < 4; q++) begin
        send_byte(w[8*q +: 8]);
        cs = cs ^ w[8*q +: 8];
      end
    end
    send_byte(cs);
    check_final("fullsize", 1'b1, 1'b0, int'(MaxW));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
